// File: rtl/branch_update_queue_pkg.sv
// Shared fetch-unit types: branch result bundle and update queue sizing.
// Imported by the branch update queue and its lane compactor.
package FetchUnitTypes;

  localparam int INT_ISSUE_WIDTH = 2;
  localparam int ADDR_WIDTH = 32;
  localparam int GHR_WIDTH = 10;
  localparam int PHT_ENTRY_WIDTH = 2;

  localparam int BRANCH_UPDATE_QUEUE_DEPTH = 8;
  localparam int BRANCH_UPDATE_MISPRED_CNT_WIDTH = 16;

  localparam int BUQ_INDEX_WIDTH =
    $clog2(BRANCH_UPDATE_QUEUE_DEPTH);

  typedef logic [BUQ_INDEX_WIDTH-1:0]
    BranchUpdateQueueIndexPath;
  typedef logic [BUQ_INDEX_WIDTH:0]
    BranchUpdateQueueCountPath;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]      brAddr;
    logic [ADDR_WIDTH-1:0]      nextAddr;
    logic                       execTaken;
    logic                       predTaken;
    logic                       isCondBr;
    logic                       isRASPushBr;
    logic                       isRASPopBr;
    logic [GHR_WIDTH-1:0]       globalHistory;
    logic [PHT_ENTRY_WIDTH-1:0] phtPrevValue;
    logic                       mispred;
  } BranchResult;

endpackage

// File: rtl/branch_update_queue_lane_compactor.sv
// Maps per-lane valid bits to dense write offsets (count of valid lower lanes).
// Ports: valid in, offset per lane out, n = popcount(valid) out.
module branch_update_lane_compactor #(
  parameter int WIDTH = 2,
  localparam int OW = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]         valid,
  output logic [WIDTH-1:0][OW-1:0] offset,
  output logic [OW-1:0]            n
);

  logic [OW-1:0] acc;

  always_comb begin
    acc = '0;
    offset = '0;
    for (int i = 0; i < WIDTH; i++) begin
      offset[i] = acc;
      acc = acc + OW'(valid[i]);
    end
    n = acc;
  end

endmodule

// File: rtl/branch_update_queue.sv
// Lane-compacting circular FIFO of branch results feeding predictor training.
// Ports: clk, rst (async low), inValid/inResult/inReady, flush, upd*, mispredCount.
module branch_update_queue
  import FetchUnitTypes::*;
#(
  parameter int WIDTH = INT_ISSUE_WIDTH,
  parameter int DEPTH = BRANCH_UPDATE_QUEUE_DEPTH,
  parameter int CNT_WIDTH = BRANCH_UPDATE_MISPRED_CNT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        inValid,
  input  BranchResult [WIDTH-1:0] inResult,
  output logic                    inReady,
  input  logic                    flush,
  output logic                    updValid,
  input  logic                    updReady,
  output BranchResult             updResult,
  output logic [CNT_WIDTH-1:0]    mispredCount
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam int OW = $clog2(WIDTH + 1);

  logic [IW-1:0] head;
  logic [IW-1:0] tail;
  logic [CW-1:0] count;

  logic [WIDTH-1:0][OW-1:0] offset;
  logic [OW-1:0]            n;
  logic [OW-1:0]            mis_n;
  logic [CNT_WIDTH:0]       mis_sum;
  logic [CNT_WIDTH-1:0]     mis_sat;
  logic                     enq;
  logic                     deq;

  BranchResult mem [DEPTH];

  branch_update_lane_compactor #(
    .WIDTH (WIDTH)
  ) u_compactor (
    .valid  (inValid),
    .offset (offset),
    .n      (n)
  );

  // Readiness looks only at registered occupancy so the
  // producer never depends on this cycle's dequeue.
  assign inReady = count <= CW'(DEPTH - WIDTH);
  assign updValid = count != '0;
  assign updResult = updValid ? mem[head] : '0;

  assign enq = inReady && !flush;
  assign deq = updValid && updReady;

  always_comb begin
    mis_n = '0;
    for (int i = 0; i < WIDTH; i++) begin
      mis_n = mis_n
        + OW'(inValid[i] & inResult[i].mispred);
    end
  end

  assign mis_sum = {1'b0, mispredCount}
    + (CNT_WIDTH + 1)'(mis_n);
  assign mis_sat = mis_sum[CNT_WIDTH]
    ? '1 : mis_sum[CNT_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (enq) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (inValid[i]) begin
          mem[tail + IW'(offset[i])] <= inResult[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) begin
        tail <= tail + IW'(n);
      end
      if (deq) begin
        head <= head + IW'(1);
      end
      count <= count
        + (enq ? CW'(n) : '0)
        - CW'(deq);
    end
  end

  // Counter survives flush; only accepted enqueues count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mispredCount <= '0;
    end else if (enq) begin
      mispredCount <= mis_sat;
    end
  end

endmodule

// File: tb/tb_branch_update_queue.sv
// Randomized scoreboard bench for branch_update_queue.
// Stimulus pushes expected entries; a negedge monitor pops and compares.
module tb_branch_update_queue;
  import FetchUnitTypes::*;

  localparam int W = 2;
  localparam int D = 8;
  localparam int CW = 4;
  localparam int MIS_MAX = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [W-1:0]      inValid = '0;
  BranchResult [W-1:0] inResult = '0;
  logic              inReady;
  logic              flush = 1'b0;
  logic              updValid;
  logic              updReady = 1'b0;
  BranchResult       updResult;
  logic [CW-1:0]     mispredCount;

  always #5 clk = ~clk;

  branch_update_queue #(
    .WIDTH     (W),
    .DEPTH     (D),
    .CNT_WIDTH (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .inValid      (inValid),
    .inResult     (inResult),
    .inReady      (inReady),
    .flush        (flush),
    .updValid     (updValid),
    .updReady     (updReady),
    .updResult    (updResult),
    .mispredCount (mispredCount)
  );

  BranchResult exp_q[$];
  int total = 0;
  int bad = 0;
  int model_mis = 0;

  task automatic check(input string name,
                       input logic [127:0] act,
                       input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic BranchResult rand_br();
    BranchResult r;
    r.brAddr        = $urandom;
    r.nextAddr      = $urandom;
    r.execTaken     = 1'($urandom);
    r.predTaken     = 1'($urandom);
    r.isCondBr      = 1'($urandom);
    r.isRASPushBr   = 1'($urandom);
    r.isRASPopBr    = 1'($urandom);
    r.globalHistory = 10'($urandom);
    r.phtPrevValue  = 2'($urandom);
    r.mispred       = ($urandom_range(3) == 0);
    return r;
  endfunction

  // Monitor: mid-cycle compare against the reference queue.
  initial begin
    bit ev;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("rst_updValid", 128'(updValid), 128'(0));
        check("rst_inReady", 128'(inReady), 128'(1));
        check("rst_mispred", 128'(mispredCount), 128'(0));
        check("rst_result", 128'(updResult), 128'(0));
      end else begin
        ev = exp_q.size() != 0;
        check("updValid", 128'(updValid), 128'(ev));
        check("inReady", 128'(inReady),
              128'((D - exp_q.size()) >= W));
        check("mispredCount", 128'(mispredCount),
              128'(model_mis));
        if (ev)
          check("updResult", 128'(updResult),
                128'(exp_q[0]));
        else
          check("idle_result", 128'(updResult), 128'(0));
        if (ev && updReady)
          void'(exp_q.pop_front());
      end
    end
  end

  // Stimulus plus reference model effects applied at each edge.
  logic                p_flush = 1'b0;
  logic                p_acc = 1'b0;
  logic [W-1:0]        p_valid = '0;
  BranchResult [W-1:0] p_res = '0;

  initial begin
    int rdy_pct;
    int vld_pct;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      if (rst) begin
        if (p_flush) begin
          exp_q.delete();
        end else if (p_acc) begin
          for (int i = 0; i < W; i++) begin
            if (p_valid[i]) begin
              exp_q.push_back(p_res[i]);
              if (p_res[i].mispred && model_mis < MIS_MAX)
                model_mis++;
            end
          end
        end
      end
      #1;
      case ((cyc / 150) % 4)
        0: begin rdy_pct = 100; vld_pct = 50; end
        1: begin rdy_pct = 20;  vld_pct = 80; end
        2: begin rdy_pct = 70;  vld_pct = 40; end
        default: begin rdy_pct = 0; vld_pct = 90; end
      endcase
      if (cyc >= 1500 && cyc < 1503) begin
        rst = 1'b0;
        exp_q.delete();
        model_mis = 0;
        inValid = '0;
        flush = 1'b0;
        updReady = 1'b0;
        p_flush = 1'b0;
        p_acc = 1'b0;
        p_valid = '0;
      end else begin
        rst = 1'b1;
        for (int i = 0; i < W; i++) begin
          inValid[i] = ($urandom_range(99) < vld_pct);
          inResult[i] = rand_br();
        end
        updReady = ($urandom_range(99) < rdy_pct);
        flush = ($urandom_range(99) < 3);
        p_flush = flush;
        p_acc = (D - exp_q.size()) >= W;
        p_valid = inValid;
        p_res = inResult;
      end
    end
    @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
